// File: rtl/sa_oport_sched.sv
// sa_oport_sched: switch-allocator scheduler for one output port.
// It picks an input round-robin and keeps that input locked from the head flit to the tail flit.
// It tracks downstream buffer credits, so a flit is issued only when a slot is free.
// Build option: define SA_FLIT_STATS_EN to enable the per-input 16-bit granted-flit counters.
// Without it, stat_flits reads as zero and no counter flops are built.
module sa_oport_sched #(
  parameter int N         = 5,
  parameter int BUF_DEPTH = 4,
  parameter int CRED_W    = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [N-1:0]      req,
  input  logic [N-1:0]      head,
  input  logic [N-1:0]      tail,
  input  logic              credit_in,
  output logic [N-1:0]      grant,
  output logic              flit_valid,
  output logic              locked,
  output logic [CRED_W-1:0] credit_cnt,
  output logic              credit_err,
  output logic [N*16-1:0]   stat_flits
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(BUF_DEPTH);
  localparam logic [PW-1:0]     PTR_RST  = PW'(N - 1);
  localparam logic [N-1:0]      ONE_N    = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_t;

  state_t              r_state;
  logic [PW-1:0]       r_rrPtr;
  logic [PW-1:0]       r_owner;
  logic [CRED_W-1:0]   r_creditCnt;
  logic                r_creditErr;

  logic [N-1:0]        w_eligible;
  logic                w_rrFound;
  logic [PW-1:0]       w_rrWinner;
  logic                w_creditOk;
  logic [N-1:0]        w_ownerOneHot;
  logic [N-1:0]        w_grant;

  // Only head flits may open a new packet, so IDLE arbitration ignores body and tail requests.
  assign w_eligible    = req & head;
  assign w_creditOk    = (r_creditCnt != '0);
  assign w_ownerOneHot = ONE_N << r_owner;

  // Round-robin scan that starts just after the last winner and wraps modulo N.
  always_comb begin
    int idx;
    w_rrFound  = 1'b0;
    w_rrWinner = '0;
    idx        = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(r_rrPtr) + k) % N;
      if (!w_rrFound && w_eligible[idx]) begin
        w_rrFound  = 1'b1;
        w_rrWinner = PW'(idx);
      end
    end
  end

  // Zero-latency grant from the registered state. It is suppressed while reset is held or when no credit is available.
  always_comb begin
    w_grant = '0;
    if (rstn && w_creditOk) begin
      case (r_state)
        S_IDLE: begin
          if (w_rrFound) begin
            w_grant = ONE_N << w_rrWinner;
          end
        end
        S_LOCKED: begin
          if (req[r_owner]) begin
            w_grant = w_ownerOneHot;
          end
        end
        default: w_grant = '0;
      endcase
    end
  end

  assign grant      = w_grant;
  assign flit_valid = |w_grant;

  // Packet-lock FSM. A head flit without a tail locks the port to its input.
  // The matching tail flit releases the lock and records the owner as the new round-robin base.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_rrPtr <= PTR_RST;
      r_owner <= '0;
    end else if (flit_valid) begin
      case (r_state)
        S_IDLE: begin
          if (tail[w_rrWinner]) begin
            r_rrPtr <= w_rrWinner;
          end else begin
            r_state <= S_LOCKED;
            r_owner <= w_rrWinner;
          end
        end
        S_LOCKED: begin
          if (tail[r_owner]) begin
            r_state <= S_IDLE;
            r_rrPtr <= r_owner;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Downstream credit counter. A credit that arrives in the same cycle as a grant cancels it.
  // A credit that arrives when the counter is already full is dropped and sets the sticky error flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_creditCnt <= CRED_MAX;
      r_creditErr <= 1'b0;
    end else if (credit_in && !flit_valid) begin
      if (r_creditCnt == CRED_MAX) begin
        r_creditErr <= 1'b1;
      end else begin
        r_creditCnt <= r_creditCnt + 1'b1;
      end
    end else if (!credit_in && flit_valid) begin
      r_creditCnt <= r_creditCnt - 1'b1;
    end
  end

  assign locked     = (r_state == S_LOCKED);
  assign credit_cnt = r_creditCnt;
  assign credit_err = r_creditErr;

`ifdef SA_FLIT_STATS_EN
  logic [15:0] r_statCnt [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_stat
    // Free-running 16-bit count of flits granted to this input; it wraps naturally.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_statCnt[gi] <= '0;
      end else if (w_grant[gi]) begin
        r_statCnt[gi] <= r_statCnt[gi] + 16'd1;
      end
    end
    assign stat_flits[16*gi +: 16] = r_statCnt[gi];
  end
`else
  assign stat_flits = '0;
`endif

endmodule

// File: tb/tb_sa_oport_sched.sv
// tb_sa_oport_sched: scoreboard bench for sa_oport_sched.
// The stimulus process computes the expected response from a packet-level model and queues it.
// A monitor process pops each queued entry and compares it with the DUT outputs on the falling edge.
module tb_sa_oport_sched;

  localparam int N = 5;
  localparam int BUF_DEPTH = 4;
`ifdef SA_FLIT_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic         clk;
  logic         rstn;
  logic [4:0]   req;
  logic [4:0]   head;
  logic [4:0]   tail;
  logic         credit_in;
  logic [4:0]   grant;
  logic         flit_valid;
  logic         locked;
  logic [2:0]   credit_cnt;
  logic         credit_err;
  logic [79:0]  stat_flits;

  sa_oport_sched #(.N(N), .BUF_DEPTH(BUF_DEPTH), .CRED_W(3)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req        (req),
    .head       (head),
    .tail       (tail),
    .credit_in  (credit_in),
    .grant      (grant),
    .flit_valid (flit_valid),
    .locked     (locked),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err),
    .stat_flits (stat_flits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  grant;
    logic        fv;
    logic        lck;
    logic [2:0]  cnt;
    logic        err;
    logic [79:0] stats;
    int          dirGrant;
    int          dirCnt;
    int          dirErr;
  } exp_t;

  exp_t expQ[$];

  int nVectors = 0;
  int nMiscompares = 0;

  // Packet-level reference state: the lock owner, the last winner, the free-slot count, and flits per input.
  bit mLocked;
  int mOwner;
  int mLast;
  int mCred;
  bit mErr;
  int mStats[N];

  task automatic modelReset();
    mLocked = 1'b0;
    mOwner  = 0;
    mLast   = N - 1;
    mCred   = BUF_DEPTH;
    mErr    = 1'b0;
    for (int i = 0; i < N; i++) mStats[i] = 0;
  endtask

  function automatic int modelPick(logic [4:0] elig);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (mLast + k) % N;
      if (elig[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, queue the expected response, then advance the model on the clock edge.
  task automatic applyStimulus(input logic [4:0] r, input logic [4:0] h, input logic [4:0] t,
                               input logic c, input logic rst,
                               input int dG, input int dC, input int dE);
    exp_t e;
    int w;
    logic [4:0] g;
    req = r; head = h; tail = t; credit_in = c; rstn = !rst;
    if (rst) modelReset();
    g = '0;
    w = -1;
    if (!rst && mCred > 0) begin
      if (!mLocked) begin
        w = modelPick(r & h);
        if (w >= 0) g = 5'(1) << w;
      end else if (r[mOwner]) begin
        w = mOwner;
        g = 5'(1) << w;
      end
    end
    e.grant = g;
    e.fv    = |g;
    e.lck   = mLocked;
    e.cnt   = 3'(mCred);
    e.err   = mErr;
    e.stats = '0;
    for (int i = 0; i < N; i++) e.stats[16*i +: 16] = STATS_EN ? 16'(mStats[i]) : 16'h0;
    e.dirGrant = dG;
    e.dirCnt   = dC;
    e.dirErr   = dE;
    expQ.push_back(e);
    @(posedge clk);
    if (!rst) begin
      if (g != 0) begin
        mStats[w] = (mStats[w] + 1) & 32'hFFFF;
        if (!mLocked) begin
          if (t[w]) mLast = w;
          else begin
            mLocked = 1'b1;
            mOwner  = w;
          end
        end else if (t[w]) begin
          mLocked = 1'b0;
          mLast   = w;
        end
      end
      if (c && g == 0 && mCred == BUF_DEPTH) mErr = 1'b1;
      else mCred = mCred + int'(c) - int'(g != 0);
    end
    #1;
  endtask

  task automatic step(input logic [4:0] r, input logic [4:0] h, input logic [4:0] t,
                      input logic c, input int dG);
    applyStimulus(r, h, t, c, 1'b0, dG, -1, -1);
  endtask

  task automatic doReset();
    applyStimulus(5'b0, 5'b0, 5'b0, 1'b0, 1'b1, 0, BUF_DEPTH, 0);
  endtask

  // Monitor: compare every queued expectation against the DUT outputs away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("grant", 80'(grant), 80'(e.grant));
        checkOutput("flit_valid", 80'(flit_valid), 80'(e.fv));
        checkOutput("locked", 80'(locked), 80'(e.lck));
        checkOutput("credit_cnt", 80'(credit_cnt), 80'(e.cnt));
        checkOutput("credit_err", 80'(credit_err), 80'(e.err));
        checkOutput("stat_flits", stat_flits, e.stats);
        if (e.dirGrant >= 0) checkOutput("directed_grant", 80'(grant), 80'(e.dirGrant));
        if (e.dirCnt >= 0) checkOutput("directed_credit_cnt", 80'(credit_cnt), 80'(e.dirCnt));
        if (e.dirErr >= 0) checkOutput("directed_credit_err", 80'(credit_err), 80'(e.dirErr));
      end
    end
  end

  // Directed scenarios followed by randomized traffic with occasional resets.
  initial begin
    logic [4:0] r, h, t;
    logic c, rs;
    rstn = 1'b0; req = '0; head = '0; tail = '0; credit_in = 1'b0;
    modelReset();
    @(posedge clk);
    #1;

    $display("[TB] round-robin");
    doReset();
    step(5'b10101, 5'b10101, 5'b10101, 1'b0, 5'b00001);
    step(5'b10101, 5'b10101, 5'b10101, 1'b0, 5'b00100);
    step(5'b10101, 5'b10101, 5'b10101, 1'b0, 5'b10000);
    step(5'b10001, 5'b10001, 5'b10001, 1'b0, 5'b00001);

    $display("[TB] wormhole lock");
    doReset();
    step(5'b00100, 5'b00100, 5'b00000, 1'b1, 5'b00100);
    step(5'b00101, 5'b00001, 5'b00000, 1'b1, 5'b00100);
    step(5'b00101, 5'b00001, 5'b00000, 1'b1, 5'b00100);
    step(5'b00101, 5'b00001, 5'b00100, 1'b1, 5'b00100);
    step(5'b00001, 5'b00001, 5'b00001, 1'b1, 5'b00001);

    $display("[TB] credit stall");
    doReset();
    step(5'b00010, 5'b00010, 5'b00000, 1'b0, 5'b00010);
    step(5'b00010, 5'b00000, 5'b00000, 1'b0, 5'b00010);
    step(5'b00010, 5'b00000, 5'b00000, 1'b0, 5'b00010);
    step(5'b00010, 5'b00000, 5'b00000, 1'b0, 5'b00010);
    applyStimulus(5'b00010, 5'b00000, 5'b00000, 1'b0, 1'b0, 0, 0, -1);
    step(5'b00010, 5'b00000, 5'b00000, 1'b1, 0);
    step(5'b00010, 5'b00000, 5'b00000, 1'b0, 5'b00010);
    applyStimulus(5'b00010, 5'b00000, 5'b00010, 1'b0, 1'b0, 0, 0, -1);
    step(5'b00010, 5'b00000, 5'b00010, 1'b1, 0);
    step(5'b00010, 5'b00000, 5'b00010, 1'b0, 5'b00010);
    step(5'b00000, 5'b00000, 5'b00000, 1'b0, 0);

    $display("[TB] simultaneous credit and grant");
    doReset();
    step(5'b00001, 5'b00001, 5'b00001, 1'b0, 5'b00001);
    step(5'b00001, 5'b00001, 5'b00001, 1'b0, 5'b00001);
    applyStimulus(5'b00001, 5'b00001, 5'b00001, 1'b1, 1'b0, 5'b00001, 2, 0);
    applyStimulus(5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0, 0, 2, 0);
    applyStimulus(5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0, 0, 3, 0);
    applyStimulus(5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0, 0, 4, 0);
    applyStimulus(5'b00000, 5'b00000, 5'b00000, 1'b0, 1'b0, 0, 4, 1);

    $display("[TB] reset mid-packet");
    doReset();
    step(5'b01000, 5'b01000, 5'b00000, 1'b0, 5'b01000);
    applyStimulus(5'b01000, 5'b00000, 5'b00000, 1'b0, 1'b1, 0, 4, 0);
    step(5'b01001, 5'b00001, 5'b00001, 1'b0, 5'b00001);

`ifdef SA_FLIT_STATS_EN
    $display("[TB] flit statistics");
    doReset();
    for (int i = 0; i < 10; i++) step(5'b10000, 5'b10000, 5'b10000, 1'b1, 5'b10000);
    step(5'b00000, 5'b00000, 5'b00000, 1'b0, 0);
    doReset();
    for (int i = 0; i < 65536; i++) step(5'b10000, 5'b10000, 5'b10000, 1'b1, 5'b10000);
    step(5'b00000, 5'b00000, 5'b00000, 1'b0, 0);
`endif

    $display("[TB] random traffic");
    doReset();
    for (int i = 0; i < 3000; i++) begin
      r  = 5'($urandom) | 5'($urandom);
      h  = 5'($urandom);
      t  = 5'($urandom) & 5'($urandom);
      c  = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 299) == 0);
      applyStimulus(r, h, t, c, rs, -1, -1, -1);
    end
    step(5'b00000, 5'b00000, 5'b00000, 1'b0, 0);

    repeat (2) @(posedge clk);
    nVectors++;
    if (expQ.size() != 0) begin
      nMiscompares++;
      $display("[TB] FAIL drain: got %0d pending entries expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
